// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants, state type and round-robin pick for the 4:1 stream mux

package stream_mux_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } mux_state_t;

   // Returns {found, idx}; scanning from the far end keeps the closest-to-ptr hit.
   function automatic logic [SEL_W:0] rr_pick(input logic [NUM_CH-1:0] valid,
                                              input logic [SEL_W-1:0]  ptr);
      logic [SEL_W:0]   res;
      logic [SEL_W-1:0] idx;
      res = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = ptr + SEL_W'(k);
         if (valid[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-way round-robin arbiter owning the search pointer

module rr_arbiter4
   import stream_mux_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req,
   input  logic              advance,
   output logic [NUM_CH-1:0] grant_oh,
   output logic [SEL_W-1:0]  grant_idx
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W:0]   pick;

   assign pick      = rr_pick(req, ptr);
   assign grant_idx = pick[SEL_W-1:0];
   assign grant_oh  = pick[SEL_W] ? (NUM_CH'(1) << grant_idx) : '0;

   // Pointer moves past the winner only when its word is actually taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= grant_idx + SEL_W'(1);
      end
   end

endmodule

// File: rtl/stream_mux4to1.sv
// rtl/stream_mux4to1.sv - four-channel round-robin stream collector with registered, tagged output

module stream_mux4to1
   import stream_mux_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CH*WIDTH-1:0]   in_data,
   input  logic [NUM_CH-1:0]         in_valid,
   output logic [NUM_CH-1:0]         in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
   output logic                      out_valid,
   input  logic                      out_ready
);

   mux_state_t        state;
   mux_state_t        state_nxt;
   logic              load_en;
   logic              in_xfer;
   logic              out_xfer;
   logic [NUM_CH-1:0] grant_oh;
   logic [SEL_W-1:0]  grant_idx;
   logic [WIDTH-1:0]  ch_data [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_split
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   assign out_valid = (state == ST_FULL);
   assign load_en   = !out_valid | out_ready;
   // No handshake is offered while reset is held.
   assign in_ready  = (rst_n && load_en) ? grant_oh : '0;
   assign in_xfer   = |(in_valid & in_ready);
   assign out_xfer  = out_valid & out_ready;

   rr_arbiter4 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (in_valid),
      .advance   (in_xfer),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (in_xfer) state_nxt = ST_FULL;
         ST_FULL:  if (out_xfer && !in_xfer) state_nxt = ST_EMPTY;
         default:  state_nxt = ST_EMPTY;
      endcase
   end

   // Data and tag only move on an accepted input word; drains leave them as-is.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_sel  <= '0;
      end else if (in_xfer) begin
         out_data <= ch_data[grant_idx];
         out_sel  <= grant_idx;
      end
   end

endmodule
